// File: rtl/alu_seq_ctrl.sv
// Accumulator-machine sequencer: fetches 1/2-byte instructions over a req/ack port,
// drives the external 8-bit ALU and commits its result to acc/carry, handles JMP/JC/HALT.
module alu_seq_ctrl #(
   parameter logic [7:0] RESET_PC = 8'h00,
   parameter int         TIMEOUT  = 255   // 0 disables the fetch timeout; max 255
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       mem_req,
   output logic [7:0] mem_addr,
   input  logic       mem_ack,
   input  logic [7:0] mem_rdata,
   output logic [4:0] alu,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   input  logic [7:0] alu_dout,
   input  logic       alu_carry,
   output logic [7:0] acc,
   output logic       carry,
   output logic [7:0] pc,
   output logic       halted,
   output logic       err
);

   localparam logic [4:0] ALU_ADD   = 5'b00000;
   localparam logic [4:0] ALU_AND   = 5'b00001;
   localparam logic [4:0] ALU_INP_A = 5'b00010;
   localparam logic [4:0] ALU_INP_B = 5'b00011;
   localparam logic [4:0] ALU_SUB   = 5'b01100;
   localparam logic [4:0] ALU_INC   = 5'b10100;

   typedef enum logic [1:0] {FETCH_OP, FETCH_ARG, EXEC, HALT} state_t;

   state_t     state;
   logic [3:0] opcode;
   logic [7:0] operand;
   logic [7:0] wait_cnt;
   logic       timeout_hit;

   function automatic logic [4:0] alu_code(input logic [3:0] op);
      case (op)
         4'h1:    alu_code = ALU_ADD;
         4'h2:    alu_code = ALU_AND;
         4'h3:    alu_code = ALU_INP_B;
         4'h4:    alu_code = ALU_SUB;
         4'h5:    alu_code = ALU_INC;
         default: alu_code = ALU_INP_A;
      endcase
   endfunction

   assign alu_a    = acc;
   assign alu_b    = operand;
   assign mem_addr = pc;
   assign halted   = (state == HALT);

   // Counter reaches TIMEOUT-1 on the TIMEOUT-th unacknowledged request cycle.
   assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == 8'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FETCH_OP;
         pc       <= RESET_PC;
         acc      <= 8'h00;
         carry    <= 1'b0;
         operand  <= 8'h00;
         opcode   <= 4'h0;
         err      <= 1'b0;
         mem_req  <= 1'b0;
         alu      <= ALU_INP_A;
         wait_cnt <= 8'h00;
      end else begin
         case (state)
            FETCH_OP: begin
               mem_req <= 1'b1;
               if (mem_req && mem_ack) begin
                  opcode   <= mem_rdata[7:4];
                  pc       <= pc + 8'h01;
                  wait_cnt <= 8'h00;
                  case (mem_rdata[7:4])
                     4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7: state <= FETCH_ARG;
                     4'h5: begin
                        state   <= EXEC;
                        mem_req <= 1'b0;
                        alu     <= ALU_INC;
                     end
                     4'h0: state <= FETCH_OP;
                     4'hF: begin
                        state   <= HALT;
                        mem_req <= 1'b0;
                     end
                     default: err <= 1'b1;  // illegal opcode behaves as NOP
                  endcase
               end else if (mem_req) begin
                  if (timeout_hit) begin
                     err     <= 1'b1;
                     state   <= HALT;
                     mem_req <= 1'b0;
                  end else begin
                     wait_cnt <= wait_cnt + 8'h01;
                  end
               end
            end
            FETCH_ARG: begin
               if (mem_ack) begin
                  operand  <= mem_rdata;
                  pc       <= pc + 8'h01;
                  wait_cnt <= 8'h00;
                  state    <= EXEC;
                  mem_req  <= 1'b0;
                  alu      <= alu_code(opcode);
               end else if (timeout_hit) begin
                  err     <= 1'b1;
                  state   <= HALT;
                  mem_req <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + 8'h01;
               end
            end
            EXEC: begin
               if (opcode >= 4'h1 && opcode <= 4'h5) begin
                  acc   <= alu_dout;
                  carry <= alu_carry;
               end
               if (opcode == 4'h6 || (opcode == 4'h7 && carry))
                  pc <= operand;
               alu     <= ALU_INP_A;
               mem_req <= 1'b1;
               state   <= FETCH_OP;
            end
            default: begin
               mem_req <= 1'b0;
               alu     <= ALU_INP_A;
            end
         endcase
      end
   end

endmodule
